// File: rtl/jump_ctrl_if.sv
// Bundle between the decode stage / program counter and the jump controller.
// Protocol: there is no backpressure. Every request (br_en, call_en, ret_en,
// lut_we) is a single-cycle strobe that is consumed at the next rising clock
// edge. The jump decision (absjump_en/target) responds combinationally in the
// same cycle. The stack status outputs reflect registered state only.
interface jump_ctrl_if #(
  parameter int D = 10,
  parameter int L = 5
);
  logic [D-1:0] prog_ctr;
  logic         br_en;
  logic         br_cond;
  logic         call_en;
  logic         ret_en;
  logic [L-1:0] br_idx;
  logic         lut_we;
  logic [L-1:0] lut_waddr;
  logic [D-1:0] lut_wdata;
  logic         absjump_en;
  logic [D-1:0] target;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  modport master (
    output prog_ctr, br_en, br_cond, call_en, ret_en, br_idx,
           lut_we, lut_waddr, lut_wdata,
    input  absjump_en, target, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  prog_ctr, br_en, br_cond, call_en, ret_en, br_idx,
           lut_we, lut_waddr, lut_wdata,
    output absjump_en, target, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump controller: resolves branches through a programmable target LUT, and
// handles calls/returns through a small return-address stack. The jump
// decision is combinational, while the LUT and stack update on the clock edge.
module jump_ctrl #(
  parameter int D     = 10,
  parameter int L     = 5,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  jump_ctrl_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  logic [D-1:0]   lut_q   [2**L];
  logic [D-1:0]   stack_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic           jump_en;
  logic [D-1:0]   jump_tgt;
  logic [D-1:0]   lut_rd;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;
  logic [D-1:0]   ret_addr;

  // The LUT read is combinational, so a same-cycle write is seen only from the next cycle.
  assign lut_rd   = lut_q[bus.br_idx];
  assign top_idx  = IW'(sp_q - 1'b1);
  assign push_idx = IW'(sp_q);
  assign ret_addr = bus.prog_ctr + 1'b1;

  // Decide the jump and the next stack state with priority ret > call > branch.
  always_comb begin
    jump_en  = 1'b0;
    jump_tgt = '0;
    sp_d     = sp_q;
    err_d    = err_q;
    push     = 1'b0;
    if (reset) begin
      // Outputs are held at zero, and any pending push/pop is dropped.
      jump_en  = 1'b0;
    end else if (bus.ret_en) begin
      if (sp_q != '0) begin
        jump_en  = 1'b1;
        jump_tgt = stack_q[top_idx];
        sp_d     = sp_q - 1'b1;
      end else begin
        err_d    = 1'b1;
      end
    end else if (bus.call_en) begin
      if (sp_q != SPW'(DEPTH)) begin
        jump_en  = 1'b1;
        jump_tgt = lut_rd;
        push     = 1'b1;
        sp_d     = sp_q + 1'b1;
      end else begin
        err_d    = 1'b1;
      end
    end else if (bus.br_en) begin
      jump_en  = bus.br_cond;
      jump_tgt = bus.br_cond ? lut_rd : '0;
    end
  end

  // Stack pointer, sticky error flag and LUT contents, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 2**L; i++) lut_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      if (bus.lut_we) lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // Return-address storage. It needs no reset because sp gates every read.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= ret_addr;
  end

  assign bus.absjump_en  = jump_en;
  assign bus.target      = jump_tgt;
  assign bus.stack_full  = (sp_q == SPW'(DEPTH));
  assign bus.stack_empty = (sp_q == '0);
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios followed by a randomized phase,
// checked against a queue-based behavioural model of the LUT and stack.
module tb_jump_ctrl;
  localparam int D     = 10;
  localparam int L     = 5;
  localparam int DEPTH = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jump_ctrl_if #(.D(D), .L(L)) bus();

  jump_ctrl #(.D(D), .L(L), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard state.
  int           checks = 0;
  int           errors = 0;
  logic [D-1:0] m_lut [2**L];
  logic [D-1:0] exp_q [$];
  bit           m_err;
  bit           m_known = 1'b0;
  logic         exp_en;
  logic [D-1:0] exp_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the current outputs against the model, then advance the model.
  task automatic step(input string tag);
    logic [D-1:0] nxt;
    #1;
    exp_en  = 1'b0;
    exp_tgt = '0;
    if (!reset) begin
      if (bus.ret_en) begin
        if (exp_q.size() > 0) begin
          exp_en  = 1'b1;
          exp_tgt = exp_q[exp_q.size()-1];
        end
      end else if (bus.call_en) begin
        if (exp_q.size() < DEPTH) begin
          exp_en  = 1'b1;
          exp_tgt = m_lut[bus.br_idx];
        end
      end else if (bus.br_en && bus.br_cond) begin
        exp_en  = 1'b1;
        exp_tgt = m_lut[bus.br_idx];
      end
    end
    chk({tag, ".en"}, {31'd0, bus.absjump_en}, {31'd0, exp_en});
    chk({tag, ".tgt"}, {22'd0, bus.target}, {22'd0, exp_tgt});
    if (m_known) begin
      chk({tag, ".full"},  {31'd0, bus.stack_full},  {31'd0, exp_q.size() == DEPTH});
      chk({tag, ".empty"}, {31'd0, bus.stack_empty}, {31'd0, exp_q.size() == 0});
      chk({tag, ".err"},   {31'd0, bus.stack_err},   {31'd0, m_err});
    end
    if (reset) begin
      for (int i = 0; i < 2**L; i++) m_lut[i] = '0;
      exp_q.delete();
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      if (bus.ret_en) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        else m_err = 1'b1;
      end else if (bus.call_en) begin
        if (exp_q.size() < DEPTH) begin
          nxt = bus.prog_ctr + 1'b1;
          exp_q.push_back(nxt);
        end else begin
          m_err = 1'b1;
        end
      end
      if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
    end
  endtask

  // Driver: apply one cycle of inputs on the falling edge, then check.
  task automatic drv(input logic r, input logic [D-1:0] pc, input logic br, input logic cond,
                     input logic call, input logic ret, input logic [L-1:0] idx,
                     input logic we, input logic [L-1:0] wa, input logic [D-1:0] wd,
                     input string tag);
    @(negedge clk);
    reset         = r;
    bus.prog_ctr  = pc;
    bus.br_en     = br;
    bus.br_cond   = cond;
    bus.call_en   = call;
    bus.ret_en    = ret;
    bus.br_idx    = idx;
    bus.lut_we    = we;
    bus.lut_waddr = wa;
    bus.lut_wdata = wd;
    step(tag);
  endtask

  task automatic idle(input string tag);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, tag);
  endtask

  task automatic do_reset(input string tag);
    drv(1'b1, '0, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, '0, '1, tag);
  endtask

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    do_reset("rst0");
    do_reset("rst1");
    idle("post_rst");

    // LUT write followed by a branch that is taken, then one that is not.
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 5'd3, 10'h155, "wr3");
    drv(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, '0, '0, "br_taken");
    chk("br_taken_const", {22'd0, bus.target}, 32'h155);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, '0, '0, "br_not");

    // Call and return round trip.
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 5'd1, 10'h200, "wr1");
    drv(1'b0, 10'h010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, '0, '0, "call1");
    chk("call1_const", {22'd0, bus.target}, 32'h200);
    idle("after_call");
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0, "ret1");
    chk("ret1_const", {22'd0, bus.target}, 32'h011);
    idle("after_ret");
    chk("after_ret_empty", {31'd0, bus.stack_empty}, 32'd1);

    // Overflow: four calls fill the stack, a fifth is rejected.
    for (int i = 1; i <= 4; i++)
      drv(1'b0, D'(i), 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, '0, '0, "ovf_call");
    idle("full");
    chk("full_const", {31'd0, bus.stack_full}, 32'd1);
    drv(1'b0, 10'h005, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, '0, '0, "call5");
    idle("after_call5");
    chk("ovf_err_const", {31'd0, bus.stack_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0, "ovf_ret");
      chk("ovf_ret_const", {22'd0, bus.target}, 32'(5 - i));
    end

    // Underflow, then wrap of the return address.
    do_reset("rst_uf");
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0, "ret_empty");
    idle("uf_err");
    chk("uf_err_const", {31'd0, bus.stack_err}, 32'd1);
    drv(1'b0, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, '0, '0, "call_wrap");
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0, "ret_wrap");
    chk("wrap_const", {21'd0, bus.absjump_en, bus.target}, 32'h400);
    idle("uf_sticky");

    // Priority: call and return together act as a return.
    do_reset("rst_pri");
    drv(1'b0, 10'h020, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, '0, '0, "pri_call");
    drv(1'b0, 10'h050, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, '0, '0, "pri_both");
    chk("pri_const", {22'd0, bus.target}, 32'h021);
    idle("pri_after");
    chk("pri_empty_const", {31'd0, bus.stack_empty}, 32'd1);

    // LUT read/write collision returns the old value that cycle.
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 5'd2, 10'h0AA, "wr2a");
    drv(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 5'd2, 10'h155, "coll");
    chk("coll_old_const", {22'd0, bus.target}, 32'h0AA);
    drv(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, '0, '0, "coll_next");
    chk("coll_new_const", {22'd0, bus.target}, 32'h155);

    // Reset in the middle of a call with two entries on the stack.
    drv(1'b0, 10'h100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, '0, '0, "mid_call0");
    drv(1'b0, 10'h101, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, '0, '0, "mid_call1");
    drv(1'b1, 10'h102, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, '0, '0, "mid_rst");
    chk("mid_rst_en_const", {31'd0, bus.absjump_en}, 32'd0);
    idle("mid_after");
    chk("mid_empty_const", {31'd0, bus.stack_empty}, 32'd1);
    chk("mid_err_const", {31'd0, bus.stack_err}, 32'd0);
    for (int i = 0; i < 2**L; i++)
      drv(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, L'(i), 1'b0, '0, '0, "lut_clr");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drv(($urandom_range(0, 63) == 0),
          D'($urandom),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          L'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), L'($urandom_range(0, 7)), D'($urandom),
          "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control-flow unit directly upstream of the program counter; produces the absolute jump enable and jump target the PC loads on the next clock edge.
- Resolves three kinds of control flow:
  - conditional branches through a programmable target lookup table (LUT);
  - subroutine calls, which push a return address;
  - returns, which pop from a small hardware return-address stack.
- Outputs are combinational from current inputs and registered state. LUT and stack update on the clock edge.

Parameters:
- D, 10: program counter / target width.
- L, 5: LUT index width; LUT holds 2^L entries of D bits.
- DEPTH, 4: return-stack depth in entries (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- prog_ctr  input  D  current PC value.
- br_en  input  1  current instruction is a conditional branch.
- br_cond  input  1  branch condition flag.
- call_en  input  1  current instruction is a call.
- ret_en  input  1  current instruction is a return.
- br_idx  input  L  LUT index for branch/call target.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  L  LUT write index.
- lut_wdata  input  D  LUT write data.
- absjump_en  output  1  to PC: load target next edge.
- target  output  D  to PC: jump destination.
- stack_full  output  1  stack holds DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset: one cycle of reset high gives
  - all LUT entries = 0 and stack pointer sp = 0;
  - stack_empty = 1, stack_full = 0, stack_err = 0;
  - absjump_en = 0 and target = 0, forced while reset is high.
  - All other inputs are ignored during reset. Reset mid-call/return discards any pending push/pop.
- State: sp counts 0..DEPTH; its width is $clog2(DEPTH+1). Stack entries are D bits.
  - stack_empty = (sp == 0); stack_full = (sp == DEPTH).
- Priority when several requests are asserted in one cycle: ret_en > call_en > br_en. Lower-priority requests are ignored that cycle.
- Return, ret_en=1:
  - sp > 0: absjump_en = 1, target = stack[sp-1]; sp decrements at the edge.
  - sp == 0: absjump_en = 0, target = 0; sp unchanged; stack_err sets at the edge.
- Call, call_en=1:
  - sp < DEPTH: absjump_en = 1, target = LUT[br_idx]; at the edge stack[sp] <= prog_ctr + 1 (mod 2^D, so 2^D-1 wraps to 0) and sp increments.
  - sp == DEPTH: absjump_en = 0; no push; stack_err sets at the edge.
- Branch, br_en=1:
  - absjump_en = br_cond; target = LUT[br_idx] when taken, else 0. No stack change.
- No request: absjump_en = 0, target = 0.
- stack_err is sticky and clears only on reset.
- LUT access:
  - Read is combinational.
  - Write is synchronous on lut_we.
  - Same-cycle write and read of the same index returns the OLD value; the new value is visible the following cycle.
  - LUT writes are independent of, and concurrent with, call/ret/branch.
- Latency: jump decision is combinational in the same cycle. The PC reflects target one edge later. Stack/LUT state changes are visible the cycle after the edge.

Test Plan:
- LUT write then branch: write LUT[3]=0x155. Next cycle br_en=1, br_cond=1, br_idx=3 gives absjump_en=1, target=0x155. With br_cond=0: absjump_en=0, target=0.
- Call/return round trip: LUT[1]=0x200; prog_ctr=0x010, call_en=1, br_idx=1 gives target=0x200 and sp=1 after the edge. Later ret_en=1 gives absjump_en=1, target=0x011, and stack_empty=1 after the edge.
- Overflow: perform 4 calls from prog_ctr 0x001..0x004, then stack_full=1. A 5th call gives absjump_en=0, stack_err=1, sp stays 4. Four returns yield targets 0x005, 0x004, 0x003, 0x002 in that order.
- Underflow and wrap: ret_en on an empty stack gives absjump_en=0 and stack_err=1, persisting until reset. A call at prog_ctr=0x3FF followed by a return gives target=0x000.
- Priority and collision:
  - call_en=1 and ret_en=1 with sp=1 acts as a return only; sp becomes 0 and no push occurs.
  - lut_we to index 2 with new data while br_idx=2 reads the old value that cycle and the new value the next.
- Reset mid-operation: assert reset during call_en=1 with sp=2. Result: sp=0, stack_empty=1, stack_err=0, absjump_en=0, and LUT[any]=0 afterwards.
